// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, flag bit positions, FSM states.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_NOT = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_ASR = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } st_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SHL,
            OP_ASR, OP_SHR, OP_ADD, OP_SUB: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// NREGS x 8 register file: async clear, two operand read ports, a debug read port, one write port.
module alu_regfile #(
    parameter int NREGS = 4,
    parameter int IW    = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [IW-1:0] i_raddr1,
    output logic [7:0]    o_rdata1,
    input  logic [IW-1:0] i_raddr2,
    output logic [7:0]    o_rdata2,
    input  logic [IW-1:0] i_dbg_addr,
    output logic [7:0]    o_dbg_data
);

    logic [7:0] r_regs [NREGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= 8'h00;
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1   = r_regs[i_raddr1];
    assign o_rdata2   = r_regs[i_raddr2];
    assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one command at a time to the combinational ALU, waits a fixed settle time,
// captures Y and flags, writes Y back, and returns a response.
//   state    | meaning
//   ST_IDLE  | ready for a command; operands read and ALU ports loaded at accept
//   ST_ISSUE | ALU ports held; settle counter running down to capture
//   ST_RESP  | response presented and held until rsp_ready
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS         = 4,
    parameter int SETTLE_CYCLES = 1,
    localparam int IW           = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [IW-1:0] cmd_rd,
    input  logic [IW-1:0] cmd_rs1,
    input  logic [IW-1:0] cmd_rs2,
    input  logic          cmd_imm_en,
    input  logic [7:0]    cmd_imm,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [3:0]    alu_opcode,
    input  logic [7:0]    alu_y,
    input  logic          alu_n,
    input  logic          alu_z,
    input  logic          alu_c,
    input  logic          alu_v,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [7:0]    rsp_data,
    output logic [3:0]    rsp_flags,
    output logic          rsp_err,
    input  logic [IW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    st_t           r_state;
    logic [3:0]    r_cnt;
    logic [IW-1:0] r_rd;
    logic [7:0]    r_alu_a;
    logic [7:0]    r_alu_b;
    logic [3:0]    r_alu_op;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [7:0]    r_rsp_data;
    logic [3:0]    r_rsp_flags;
    logic [7:0]    w_rs1_data;
    logic [7:0]    w_rs2_data;
    logic          w_capture;

    assign w_capture = (r_state == ST_ISSUE) && (r_cnt == 4'd1);

    alu_regfile #(.NREGS(NREGS), .IW(IW)) u_regfile (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_we       (w_capture),
        .i_waddr    (r_rd),
        .i_wdata    (alu_y),
        .i_raddr1   (cmd_rs1),
        .o_rdata1   (w_rs1_data),
        .i_raddr2   (cmd_rs2),
        .o_rdata2   (w_rs2_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_rd        <= '0;
            r_alu_a     <= 8'h00;
            r_alu_b     <= 8'h00;
            r_alu_op    <= 4'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_rsp_flags <= 4'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (is_legal_op(cmd_op)) begin
                            r_alu_a  <= w_rs1_data;
                            r_alu_b  <= cmd_imm_en ? cmd_imm : w_rs2_data;
                            r_alu_op <= cmd_op;
                            r_rd     <= cmd_rd;
                            r_cnt    <= SETTLE_LD;
                            r_state  <= ST_ISSUE;
                        end else begin
                            // Flags deliberately keep the previous capture.
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= 8'h00;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_cnt == 4'd1) begin
                        r_rsp_data          <= alu_y;
                        r_rsp_flags[FLAG_N] <= alu_n;
                        r_rsp_flags[FLAG_Z] <= alu_z;
                        r_rsp_flags[FLAG_C] <= alu_c;
                        r_rsp_flags[FLAG_V] <= alu_v;
                        r_rsp_err           <= 1'b0;
                        r_rsp_valid         <= 1'b1;
                        r_state             <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = rst_n && (r_state == ST_IDLE);
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_data   = r_rsp_data;
    assign rsp_flags  = r_rsp_flags;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed test-plan steps plus random commands
// checked against an array-based register model and an arithmetic ALU model.
module tb_alu_issue_ctrl;

    localparam int SETTLE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'h0;
    logic [1:0] cmd_rd = 2'd0;
    logic [1:0] cmd_rs1 = 2'd0;
    logic [1:0] cmd_rs2 = 2'd0;
    logic       cmd_imm_en = 1'b0;
    logic [7:0] cmd_imm = 8'h00;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_y;
    logic       alu_n, alu_z, alu_c, alu_v;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic       rsp_err;
    logic [1:0] dbg_addr = 2'd0;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_regs [4];
    logic [3:0] m_flags;
    logic [3:0] m_op;

    alu_issue_ctrl #(.NREGS(4), .SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_y      (alu_y),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {Y, N, Z, C, V}; V on non-arithmetic ops is parity so passthrough is visible.
    function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] y;
        logic       c, v;
        s = 9'd0; y = 8'h00; c = 1'b0; v = 1'b0;
        case (op)
            4'd1: y = a & b;
            4'd2: y = a | b;
            4'd3: y = ~a;
            4'd4: y = a ^ b;
            4'd5: y = a << b;
            4'd6: y = 8'($signed(a) >>> b);
            4'd7: y = a >> b;
            4'd8: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (y[7] != a[7]);
            end
            4'd9: begin
                s = {1'b0, a} - {1'b0, b};
                y = s[7:0]; c = s[8];
                v = (a[7] != b[7]) && (y[7] != a[7]);
            end
            default: y = 8'hEE;
        endcase
        if (op < 4'd8) v = ^y;
        return {y, y[7], (y == 8'h00), c, v};
    endfunction

    always_comb {alu_y, alu_n, alu_z, alu_c, alu_v} = alu_f(alu_opcode, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk(tag, 32'(dbg_data), 32'(m_regs[i]));
        end
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic ie, input logic [7:0] imm,
                          input int hold, input bit poke);
        logic [7:0]  a, b, edata;
        logic [3:0]  eflags;
        logic [11:0] r;
        logic        legal;
        int          lat;
        legal = (op >= 4'd1) && (op <= 4'd9);
        a = m_regs[rs1];
        b = ie ? imm : m_regs[rs2];
        r = alu_f(op, a, b);
        edata  = legal ? r[11:4] : 8'h00;
        eflags = legal ? r[3:0] : m_flags;

        lat = 0;
        while (!cmd_ready && lat < 20) begin @(negedge clk); lat++; end
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);

        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_imm_en = ie; cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_rs1 = 2'($urandom); cmd_imm = 8'($urandom);

        if (legal) begin
            chk("alu_a", 32'(alu_a), 32'(a));
            chk("alu_b", 32'(alu_b), 32'(b));
            chk("alu_opcode", 32'(alu_opcode), 32'(op));
        end else begin
            chk("alu_opcode_held", 32'(alu_opcode), 32'(m_op));
        end

        lat = 1;
        while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
        chk("latency", 32'(lat), legal ? 32'(SETTLE + 1) : 32'd1);
        chk("rsp_data", 32'(rsp_data), 32'(edata));
        chk("rsp_flags", 32'(rsp_flags), 32'(eflags));
        chk("rsp_err", 32'(rsp_err), legal ? 32'd0 : 32'd1);

        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'(edata));
            chk("hold_flags", 32'(rsp_flags), 32'(eflags));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            if (poke && i == 1) begin
                cmd_valid = 1'b1; cmd_op = 4'd8; cmd_rd = 2'd0; cmd_rs1 = 2'd1;
                cmd_imm_en = 1'b1; cmd_imm = 8'h3C;
            end
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        chk("hold_end_data", 32'(rsp_data), 32'(edata));

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);

        if (legal) begin
            m_regs[rd] = edata;
            m_op = op;
            m_flags = eflags;
        end
        check_regs("regfile");
    endtask

    initial begin
        logic [3:0] rop;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_flags = 4'h0;
        m_op = 4'h0;

        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
        check_regs("rst_regs");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // ADD immediate from zero register
        do_cmd(4'd8, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 0, 1'b0);
        chk("plan_add_data", 32'(m_regs[1]), 32'h05);
        chk("plan_add_flags", 32'(m_flags), 32'h0);
        // Signed overflow
        do_cmd(4'd8, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 0, 1'b0);
        do_cmd(4'd8, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 0, 1'b0);
        chk("plan_ovf_data", 32'(m_regs[2]), 32'h80);
        chk("plan_ovf_flags", 32'(m_flags), 32'b1001);
        // Zero and carry
        do_cmd(4'd8, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF, 0, 1'b0);
        do_cmd(4'd8, 2'd3, 2'd1, 2'd0, 1'b1, 8'h01, 0, 1'b0);
        chk("plan_zc_data", 32'(m_regs[3]), 32'h00);
        chk("plan_zc_flags", 32'(m_flags), 32'b0110);
        // Illegal opcode with backpressure and an ignored command pulse
        do_cmd(4'b1100, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00, 5, 1'b1);
        // Backpressure on a legal op, rs == rd register-form
        do_cmd(4'd9, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00, 5, 1'b1);

        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) rop = 4'($urandom_range(1, 9));
            do_cmd(rop, 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                   8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Reset during ISSUE drops the command
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd8; cmd_rd = 2'd2; cmd_rs1 = 2'd1;
        cmd_imm_en = 1'b1; cmd_imm = 8'h11;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp", 32'({rsp_err, rsp_data, rsp_flags}), 32'd0);
        chk("mid_rst_alu", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_flags = 4'h0;
        m_op = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check_regs("post_rst_regs");
        do_cmd(4'd4, 2'd0, 2'd0, 2'd0, 1'b1, 8'hA5, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Command-side initiator for the team's 8-bit combinational ALU (A, B, 4-bit opcode, Y, flags N/Z/C/V).
- Accepts one operation per command over a valid/ready handshake and fetches operands from a small register file or an immediate.
- Drives the ALU input ports, waits a fixed settle time, samples Y and the flags, writes Y back to the register file, then returns a response over a second valid/ready handshake.

Parameters:
- NREGS, 4, number of 8-bit registers; index width is clog2(NREGS)
- SETTLE_CYCLES, 1, clock edges between driving the ALU ports and sampling its outputs (1..15)

Ports:
- clk  in  1  the single clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  4  ALU opcode
- cmd_rd  in  clog2(NREGS)  destination register
- cmd_rs1  in  clog2(NREGS)  source register for A
- cmd_rs2  in  clog2(NREGS)  source register for B
- cmd_imm_en  in  1  1: B = cmd_imm, 0: B = reg[rs2]
- cmd_imm  in  8  immediate operand
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_opcode  out  4  to ALU opcode
- alu_y  in  8  from ALU Y
- alu_n, alu_z, alu_c, alu_v  in  1 each  from ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  8  captured Y
- rsp_flags  out  4  {N,Z,C,V} captured
- rsp_err  out  1  illegal opcode; no writeback performed
- dbg_addr  in  clog2(NREGS)  register-file debug read index
- dbg_data  out  8  reg[dbg_addr], combinational

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: state IDLE; all registers 0; alu_a, alu_b and alu_opcode 0; rsp_valid, rsp_err, rsp_data and rsp_flags 0; cmd_ready 0 while rst_n is low and 1 on the first cycle after release.
- Legal opcodes: 0001 AND, 0010 OR, 0011 NOT, 0100 XOR, 0101 SHL, 0110 ASR, 0111 SHR, 1000 ADD, 1001 SUB. 0000 and 1010-1111 are illegal.
- FSM states:
  - IDLE: cmd_ready=1. A command is accepted on an edge where cmd_valid and cmd_ready are both high.
    - Legal opcode: at that edge, register alu_a=reg[rs1], alu_b=(imm_en ? imm : reg[rs2]) and alu_opcode=op; latch rd; load counter=SETTLE_CYCLES; go to ISSUE.
    - Illegal opcode: rsp_err=1, rsp_data=0, rsp_flags held at the previous value, no writeback, alu_* unchanged; go to RESP.
  - ISSUE: cmd_ready=0; alu_* held stable; counter decrements each edge. On the edge where counter==1: sample alu_y and the flags into rsp_data and rsp_flags, write reg[rd]=alu_y, set rsp_err=0; go to RESP.
  - RESP: rsp_valid=1; all rsp_* held stable until rsp_ready=1 at an edge, then go to IDLE. alu_* keep their last values.
- Latency: command accept at edge E0 leads to rsp_valid high after edge E0+SETTLE_CYCLES. The next command can be accepted on the edge after the rsp handshake, so maximum throughput is one op per SETTLE_CYCLES+2 cycles.
- Operand read: registers are read at the accept edge using their current contents. rs1==rd or rs2==rd uses the old value; the write happens only at capture.
- Flags: passed through exactly as the ALU produces them.
  - C is meaningful only for ADD and SUB; the ALU drives C=0 otherwise.
  - V is captured as produced for every op.
- Shifts: B is passed through unmodified; shift amounts of 8 or more are the ALU's concern.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
- Reset mid-operation (ISSUE or RESP): the in-flight command is dropped, there is no writeback, the register file clears to 0, and all outputs return to their reset values.

Decomposition:
- Shared package alu_pkg: opcode constants (OP_AND..OP_SUB), an is_legal_op function, flag bit positions (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), and the FSM state enum.
- One sub-module, alu_regfile: NREGS x 8 registers with async clear, two combinational read ports, one debug read port and one synchronous write port.

Test Plan:
- Reset, then load registers with NOP-free ADD-immediate from zero: cmd ADD rd=1, rs1=0, imm_en=1, imm=8'h05 -> after SETTLE+1 edges rsp_valid=1, rsp_data=05, flags=0000, dbg reg1=05.
- Overflow: reg1=7F, cmd ADD rd=2, rs1=1, imm=01 -> rsp_data=80, flags N=1, Z=0, C=0, V=1.
- Zero and carry: reg1=FF, cmd ADD rd=3, rs1=1, imm=01 -> rsp_data=00, N=0, Z=1, C=1.
- Illegal opcode 4'b1100 -> rsp_valid on the next cycle, rsp_err=1, rsp_data=0, register file unchanged, alu_opcode unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable and cmd_ready=0 throughout; a cmd_valid pulse during this window is ignored.
- Assert rst_n low while in ISSUE with SETTLE_CYCLES=3 -> rsp_valid never rises, reg[rd] stays 0, all outputs read 0 immediately.
